// File: rtl/spi_master_byte_buffer_if.sv
// Host-side and SPI_Master-side signals of spi_master_byte_buffer, bundled with master (host/bench) and slave (buffer) views.
// o_Overflow is present only when SPI_BUF_OVERFLOW_FLAG_EN is defined.
interface spi_master_byte_buffer_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic [7:0]          i_Wr_Byte;
  logic                i_Wr_En;
  logic                o_TX_Full;
  logic [DEPTH_LOG2:0] o_TX_Count;
  logic [7:0]          o_Rd_Byte;
  logic                i_Rd_En;
  logic                o_RX_Empty;
  logic [DEPTH_LOG2:0] o_RX_Count;
  logic                o_Busy;
  logic [7:0]          o_TX_Byte;
  logic                o_TX_DV;
  logic                i_TX_Ready;
  logic                i_RX_DV;
  logic [7:0]          i_RX_Byte;
`ifdef SPI_BUF_OVERFLOW_FLAG_EN
  logic                o_Overflow;

  modport master (
    output i_Wr_Byte, i_Wr_En, i_Rd_En, i_TX_Ready, i_RX_DV, i_RX_Byte,
    input  o_TX_Full, o_TX_Count, o_Rd_Byte, o_RX_Empty, o_RX_Count, o_Busy,
           o_TX_Byte, o_TX_DV, o_Overflow
  );

  modport slave (
    input  i_Wr_Byte, i_Wr_En, i_Rd_En, i_TX_Ready, i_RX_DV, i_RX_Byte,
    output o_TX_Full, o_TX_Count, o_Rd_Byte, o_RX_Empty, o_RX_Count, o_Busy,
           o_TX_Byte, o_TX_DV, o_Overflow
  );
`else
  modport master (
    output i_Wr_Byte, i_Wr_En, i_Rd_En, i_TX_Ready, i_RX_DV, i_RX_Byte,
    input  o_TX_Full, o_TX_Count, o_Rd_Byte, o_RX_Empty, o_RX_Count, o_Busy,
           o_TX_Byte, o_TX_DV
  );

  modport slave (
    input  i_Wr_Byte, i_Wr_En, i_Rd_En, i_TX_Ready, i_RX_DV, i_RX_Byte,
    output o_TX_Full, o_TX_Count, o_Rd_Byte, o_RX_Empty, o_RX_Count, o_Busy,
           o_TX_Byte, o_TX_DV
  );
`endif
endinterface

// File: rtl/spi_master_byte_buffer.sv
// TX/RX byte FIFOs around SPI_Master: a feeder FSM hands queued bytes over one at a time, every received byte is captured.
// Define SPI_BUF_OVERFLOW_FLAG_EN to add the sticky o_Overflow flag for dropped TX writes / RX pushes.
module spi_master_byte_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  spi_master_byte_buffer_if.slave  bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            txByte_q, txByte_d;
  logic                  txDv_q, txDv_d;

  logic [7:0]            txMem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] txWrPtr_q, txRdPtr_q;
  logic [DEPTH_LOG2:0]   txCount_q;
  logic                  txFull, txEmpty, txPush, txPop;

  logic [7:0]            rxMem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rxWrPtr_q, rxRdPtr_q, rxRdPtrNext;
  logic [DEPTH_LOG2:0]   rxCount_q, rxCountNext;
  logic                  rxFull, rxEmpty, rxPush, rxPop;
  logic [7:0]            rdByte_q, rdByte_d;

  assign txFull  = (txCount_q == FULL_COUNT);
  assign txEmpty = (txCount_q == '0);
  assign txPush  = bus.i_Wr_En && !txFull;

  assign rxFull  = (rxCount_q == FULL_COUNT);
  assign rxEmpty = (rxCount_q == '0);
  assign rxPush  = bus.i_RX_DV && !rxFull;
  assign rxPop   = bus.i_Rd_En && !rxEmpty;

  always_comb begin
    state_d  = state_q;
    txByte_d = txByte_q;
    txDv_d   = 1'b0;
    txPop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!txEmpty && bus.i_TX_Ready) begin
          txByte_d = txMem_q[txRdPtr_q];
          txDv_d   = 1'b1;
          txPop    = 1'b1;
          state_d  = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!bus.i_TX_Ready) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (bus.i_TX_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The registered read head must show the new head after this cycle; a byte pushed into a slot that becomes the head bypasses memory.
  always_comb begin
    rxRdPtrNext = rxPop ? (rxRdPtr_q + ONE_PTR) : rxRdPtr_q;
    rxCountNext = rxCount_q;
    case ({rxPush, rxPop})
      2'b10:   rxCountNext = rxCount_q + ONE_COUNT;
      2'b01:   rxCountNext = rxCount_q - ONE_COUNT;
      default: rxCountNext = rxCount_q;
    endcase
    rdByte_d = rdByte_q;
    if (rxCountNext != '0) begin
      if (rxPush && (rxRdPtrNext == rxWrPtr_q)) rdByte_d = bus.i_RX_Byte;
      else                                     rdByte_d = rxMem_q[rxRdPtrNext];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (txPush) txMem_q[txWrPtr_q] <= bus.i_Wr_Byte;
    if (rxPush) rxMem_q[rxWrPtr_q] <= bus.i_RX_Byte;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      txByte_q  <= 8'h00;
      txDv_q    <= 1'b0;
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
      txCount_q <= '0;
      rxWrPtr_q <= '0;
      rxRdPtr_q <= '0;
      rxCount_q <= '0;
      rdByte_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      txByte_q <= txByte_d;
      txDv_q   <= txDv_d;
      if (txPush) txWrPtr_q <= txWrPtr_q + ONE_PTR;
      if (txPop)  txRdPtr_q <= txRdPtr_q + ONE_PTR;
      case ({txPush, txPop})
        2'b10:   txCount_q <= txCount_q + ONE_COUNT;
        2'b01:   txCount_q <= txCount_q - ONE_COUNT;
        default: txCount_q <= txCount_q;
      endcase
      if (rxPush) rxWrPtr_q <= rxWrPtr_q + ONE_PTR;
      rxRdPtr_q <= rxRdPtrNext;
      rxCount_q <= rxCountNext;
      rdByte_q  <= rdByte_d;
    end
  end

`ifdef SPI_BUF_OVERFLOW_FLAG_EN
  logic overflow_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      overflow_q <= 1'b0;
    end else if ((bus.i_Wr_En && txFull) || (bus.i_RX_DV && rxFull)) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.o_Overflow = overflow_q;
`endif

  assign bus.o_TX_Full  = txFull;
  assign bus.o_TX_Count = txCount_q;
  assign bus.o_Rd_Byte  = rdByte_q;
  assign bus.o_RX_Empty = rxEmpty;
  assign bus.o_RX_Count = rxCount_q;
  assign bus.o_Busy     = !txEmpty || (state_q != IDLE);
  assign bus.o_TX_Byte  = txByte_q;
  assign bus.o_TX_DV    = txDv_q;

endmodule

// File: tb/tb_spi_master_byte_buffer.sv
// Bench for spi_master_byte_buffer: a behavioural loopback SPI_Master stand-in, expected-byte queues and a decoupled monitor.
module tb_spi_master_byte_buffer;

  localparam int DEPTH_LOG2 = 4;
  localparam int SPI_CYCLES = 20;

  logic i_Clk   = 1'b0;
  logic i_Rst_L = 1'b0;

  spi_master_byte_buffer_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  spi_master_byte_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .bus     (bus.slave)
  );

  always #5 i_Clk = ~i_Clk;

  int vectors     = 0;
  int miscompares = 0;
  int dvPulses    = 0;

  logic [7:0] txExpQ[$];
  logic [7:0] rxExpQ[$];

  logic       modelReady  = 1'b1;
  logic       modelRxDv   = 1'b0;
  logic [7:0] modelRxByte = 8'h00;
  logic [7:0] shiftByte   = 8'h00;
  int         busyCnt     = 0;
  logic       holdReady   = 1'b0;
  logic       stimRxDv    = 1'b0;
  logic [7:0] stimRxByte  = 8'h00;

  assign bus.i_TX_Ready = modelReady && !holdReady;
  assign bus.i_RX_DV    = modelRxDv || stimRxDv;
  assign bus.i_RX_Byte  = modelRxDv ? modelRxByte : stimRxByte;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Loopback stand-in for SPI_Master: drops Ready on a DV, returns the same byte SPI_CYCLES later with Ready back high.
  initial begin : spiModel
    logic       dvSeen;
    logic [7:0] byteSeen;
    logic       rstSeen;
    forever begin
      @(posedge i_Clk);
      dvSeen   = bus.o_TX_DV;
      byteSeen = bus.o_TX_Byte;
      rstSeen  = i_Rst_L;
      #1;
      modelRxDv = 1'b0;
      if (!rstSeen) begin
        modelReady = 1'b1;
        busyCnt    = 0;
      end else if (busyCnt != 0) begin
        busyCnt--;
        if (busyCnt == 0) begin
          modelReady  = 1'b1;
          modelRxDv   = 1'b1;
          modelRxByte = shiftByte;
        end
      end else if (dvSeen) begin
        modelReady = 1'b0;
        shiftByte  = byteSeen;
        busyCnt    = SPI_CYCLES;
      end
    end
  end

  // Monitor: every DV pulse and every accepted read is matched against the expected queues.
  logic prevDv      = 1'b0;
  logic sawReadyLow = 1'b1;

  always @(negedge i_Clk) begin
    if (!i_Rst_L) begin
      prevDv      = 1'b0;
      sawReadyLow = 1'b1;
    end else begin
      if (bus.o_TX_DV) begin
        dvPulses++;
        checkOutput("tx_dv_single_cycle", 32'(prevDv), 32'd0);
        checkOutput("tx_ready_fall_rise", 32'(sawReadyLow), 32'd1);
        sawReadyLow = 1'b0;
        if (txExpQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL tx_unexpected: got byte %0h, expected no pulse", bus.o_TX_Byte);
        end else begin
          checkOutput("tx_byte", 32'(bus.o_TX_Byte), 32'(txExpQ.pop_front()));
        end
      end
      if (!bus.i_TX_Ready) sawReadyLow = 1'b1;
      prevDv = bus.o_TX_DV;
      if (bus.i_Rd_En && !bus.o_RX_Empty) begin
        if (rxExpQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL rd_unexpected: got byte %0h, expected empty", bus.o_Rd_Byte);
        end else begin
          checkOutput("rd_byte", 32'(bus.o_Rd_Byte), 32'(rxExpQ.pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [7:0] b, input logic rd);
    bus.i_Wr_En   = wr;
    bus.i_Wr_Byte = b;
    bus.i_Rd_En   = rd;
    @(posedge i_Clk);
    #1;
    bus.i_Wr_En = 1'b0;
    bus.i_Rd_En = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  task automatic readN(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (bus.o_Busy && n < 3000) begin
      @(posedge i_Clk);
      #1;
      n++;
    end
    checkOutput({name, "_busy_falls"}, 32'(bus.o_Busy), 32'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_tx_dv"},    32'(bus.o_TX_DV),    32'd0);
    checkOutput({name, "_tx_byte"},  32'(bus.o_TX_Byte),  32'h00);
    checkOutput({name, "_rx_empty"}, 32'(bus.o_RX_Empty), 32'd1);
    checkOutput({name, "_tx_full"},  32'(bus.o_TX_Full),  32'd0);
    checkOutput({name, "_tx_count"}, 32'(bus.o_TX_Count), 32'd0);
    checkOutput({name, "_rx_count"}, 32'(bus.o_RX_Count), 32'd0);
    checkOutput({name, "_busy"},     32'(bus.o_Busy),     32'd0);
`ifdef SPI_BUF_OVERFLOW_FLAG_EN
    checkOutput({name, "_overflow"}, 32'(bus.o_Overflow), 32'd0);
`endif
  endtask

  task automatic pulseReset(input string name);
    i_Rst_L = 1'b0;
    txExpQ.delete();
    rxExpQ.delete();
    @(posedge i_Clk);
    #1;
    checkResetValues(name);
    i_Rst_L = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int base;
    int n;
    logic [7:0] burst [3];
    burst[0] = 8'hBE;
    burst[1] = 8'hEF;
    burst[2] = 8'h01;

    bus.i_Wr_En   = 1'b0;
    bus.i_Wr_Byte = 8'h00;
    bus.i_Rd_En   = 1'b0;
    i_Rst_L       = 1'b0;
    repeat (10) @(posedge i_Clk);
    #1;
    checkResetValues("reset");
    i_Rst_L = 1'b1;
    idle(2);

    $display("[TB] single byte C1");
    base = dvPulses;
    txExpQ.push_back(8'hC1);
    rxExpQ.push_back(8'hC1);
    applyStimulus(1'b1, 8'hC1, 1'b0);
    @(posedge i_Clk);
    #1;
    checkOutput("c1_latency_dv", 32'(bus.o_TX_DV), 32'd1);
    checkOutput("c1_latency_byte", 32'(bus.o_TX_Byte), 32'hC1);
    idle(1);
    checkOutput("c1_dv_drops", 32'(bus.o_TX_DV), 32'd0);
    waitIdle("c1");
    checkOutput("c1_pulse_count", 32'(dvPulses - base), 32'd1);
    checkOutput("c1_rx_count", 32'(bus.o_RX_Count), 32'd1);
    checkOutput("c1_rd_head", 32'(bus.o_Rd_Byte), 32'hC1);
    readN(1);
    checkOutput("c1_rx_empty_after_read", 32'(bus.o_RX_Empty), 32'd1);

    $display("[TB] burst BE EF 01");
    base = dvPulses;
    for (int i = 0; i < 3; i++) begin
      txExpQ.push_back(burst[i]);
      rxExpQ.push_back(burst[i]);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, burst[i], 1'b0);
    waitIdle("burst");
    checkOutput("burst_pulse_count", 32'(dvPulses - base), 32'd3);
    checkOutput("burst_rx_count", 32'(bus.o_RX_Count), 32'd3);
    readN(3);
    checkOutput("burst_rx_empty", 32'(bus.o_RX_Empty), 32'd1);

    $display("[TB] TX fill with Ready held low");
    holdReady = 1'b1;
    base = dvPulses;
    for (int i = 0; i < 16; i++) begin
      txExpQ.push_back(8'(i));
      rxExpQ.push_back(8'(i));
    end
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("txfill_full_after_16", 32'(bus.o_TX_Full), 32'd1);
    checkOutput("txfill_count_16", 32'(bus.o_TX_Count), 32'd16);
    applyStimulus(1'b1, 8'h10, 1'b0);
    idle(3);
    checkOutput("txfill_full_after_17", 32'(bus.o_TX_Full), 32'd1);
    checkOutput("txfill_count_still_16", 32'(bus.o_TX_Count), 32'd16);
    checkOutput("txfill_no_dv", 32'(dvPulses - base), 32'd0);
`ifdef SPI_BUF_OVERFLOW_FLAG_EN
    checkOutput("txfill_overflow", 32'(bus.o_Overflow), 32'd1);
`endif
    holdReady = 1'b0;
    waitIdle("txfill");
    checkOutput("txfill_pulse_count", 32'(dvPulses - base), 32'd16);
    checkOutput("txfill_rx_count", 32'(bus.o_RX_Count), 32'd16);
    readN(16);
    checkOutput("txfill_rx_empty", 32'(bus.o_RX_Empty), 32'd1);

    $display("[TB] RX overfill");
    pulseReset("pre_rx");
    idle(1);
    for (int i = 0; i < 16; i++) rxExpQ.push_back(8'(8'h20 + i));
    for (int i = 0; i < 17; i++) begin
      stimRxDv   = 1'b1;
      stimRxByte = 8'(8'h20 + i);
      @(posedge i_Clk);
      #1;
    end
    stimRxDv = 1'b0;
    checkOutput("rxfill_count_16", 32'(bus.o_RX_Count), 32'd16);
    checkOutput("rxfill_not_empty", 32'(bus.o_RX_Empty), 32'd0);
    checkOutput("rxfill_head", 32'(bus.o_Rd_Byte), 32'h20);
`ifdef SPI_BUF_OVERFLOW_FLAG_EN
    checkOutput("rxfill_overflow", 32'(bus.o_Overflow), 32'd1);
`endif
    readN(16);
    checkOutput("rxfill_rx_empty", 32'(bus.o_RX_Empty), 32'd1);
    checkOutput("rxfill_head_held", 32'(bus.o_Rd_Byte), 32'h2F);

    $display("[TB] reset during second transfer");
    base = dvPulses;
    for (int i = 0; i < 4; i++) begin
      txExpQ.push_back(8'(8'h61 + i));
      rxExpQ.push_back(8'(8'h61 + i));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h61 + i), 1'b0);
    n = 0;
    while ((dvPulses - base) < 2 && n < 2000) begin
      @(posedge i_Clk);
      #1;
      n++;
    end
    checkOutput("midrst_second_started", 32'(dvPulses - base), 32'd2);
    idle(5);
    pulseReset("midrst");
    idle(2);
    txExpQ.push_back(8'hA5);
    rxExpQ.push_back(8'hA5);
    base = dvPulses;
    applyStimulus(1'b1, 8'hA5, 1'b0);
    waitIdle("a5");
    checkOutput("a5_pulse_count", 32'(dvPulses - base), 32'd1);
    checkOutput("a5_rx_count", 32'(bus.o_RX_Count), 32'd1);
    readN(1);
    idle(2);

    checkOutput("tx_queue_drained", 32'(txExpQ.size()), 32'd0);
    checkOutput("rx_queue_drained", 32'(rxExpQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
